// File: rtl/stage4ma.sv
// Memory-access pipeline stage: forwards ALU results or runs one req/ack memory
// transaction per instruction, stalling execute until it completes or times out.
module stage4ma #(
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [11:0]       pc_in,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [11:0]       addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic              flush,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [11:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [11:0]       pc_out,
    output logic              enable_out,
    output logic [DATA_W-1:0] result_out,
    output logic              mem_fault
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_next;
    logic              accept, done, timed_out, kill_now;
    logic [CNT_W-1:0]  cnt;
    logic              is_rd, killed;
    logic [11:0]       pc_lat;
    logic [DATA_W-1:0] res_lat;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !flush) begin
                    accept = 1'b1;
                    if (mem_rd || mem_wr) state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Ack beats timeout when both land in the same cycle.
                if (mem_ack) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    done       = 1'b1;
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall_out = (state == ACCESS);
    assign mem_req   = (state == ACCESS);
    assign kill_now  = killed | flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            is_rd      <= 1'b0;
            killed     <= 1'b0;
            pc_lat     <= '0;
            res_lat    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pc_out     <= '0;
            enable_out <= 1'b0;
            result_out <= '0;
            mem_fault  <= 1'b0;
        end else begin
            enable_out <= 1'b0;
            mem_fault  <= 1'b0;

            if (accept) begin
                if (mem_rd || mem_wr) begin
                    mem_we    <= mem_wr & ~mem_rd;
                    is_rd     <= mem_rd;
                    mem_addr  <= addr_in;
                    mem_wdata <= wdata_in;
                    pc_lat    <= pc_in;
                    res_lat   <= result_in;
                    killed    <= 1'b0;
                    cnt       <= '0;
                end else begin
                    pc_out     <= pc_in;
                    result_out <= result_in;
                    enable_out <= 1'b1;
                end
            end

            if (state == ACCESS) begin
                if (flush) killed <= 1'b1;
                if (done) begin
                    mem_we <= 1'b0;
                    // A killed request finishes silently: no valid, no fault.
                    if (!kill_now) begin
                        enable_out <= 1'b1;
                        mem_fault  <= timed_out;
                        pc_out     <= pc_lat;
                        result_out <= timed_out ? '0 : (is_rd ? mem_rdata : res_lat);
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/stage4ma.md
Name: stage4ma

Overview:
- Memory-access pipeline stage and the consumer end of the execute-stage interface.
- Accepts pc/enable plus load/store/result fields from execute.
- Issues at most one memory transaction per instruction over a req/ack port.
- Forwards pc, a one-cycle valid and the result to writeback; stalls execute while a transaction is outstanding.

Parameters:
DATA_W, 24, width of data/result words
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before a fault (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
enable  in  1  instruction valid from execute
pc_in  in  12  instruction pc from execute
mem_rd  in  1  instruction is a load
mem_wr  in  1  instruction is a store
addr_in  in  12  load/store address
wdata_in  in  DATA_W  store data
result_in  in  DATA_W  ALU result (non-memory ops)
flush  in  1  kill current/incoming instruction
stall_out  out  1  execute must hold its outputs
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  12  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion, one-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack
pc_out  out  12  pc to writeback
enable_out  out  1  one-cycle valid to writeback
result_out  out  DATA_W  result/load data to writeback
mem_fault  out  1  timeout fault, qualified by enable_out

Behaviour:
- Reset (rst=0, any time, including mid-transaction):
  - All outputs 0; state IDLE; timeout counter 0.
  - A pending request is dropped without waiting for ack.
- States:
  - IDLE: stall_out=0.
  - ACCESS: stall_out=1, mem_req=1.
- Accept: in IDLE with enable=1 and flush=0.
- Non-memory instruction (mem_rd=mem_wr=0), accepted at edge N:
  - After edge N: pc_out=pc_in, result_out=result_in, enable_out=1 for exactly one cycle, mem_fault=0.
  - Latency 1; back-to-back accepts allowed every cycle.
- Memory instruction accepted at edge N:
  - After edge N: state=ACCESS, mem_req=1.
  - mem_we=mem_wr & ~mem_rd, so read wins when both are set and no write is performed.
  - mem_addr, mem_wdata and pc are latched; all held stable until completion.
  - enable_out=0 meanwhile.
- In ACCESS, mem_ack sampled 1 at edge M (the first ACCESS cycle qualifies):
  - After edge M: mem_req=0, state=IDLE, enable_out=1 for one cycle.
  - result_out=mem_rdata for a read; result_out=latched result_in for a write.
  - stall_out is still 1 during the ack cycle, so the next instruction is accepted no earlier than edge M+1.
- Timeout:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - If the TIMEOUT-th ACCESS cycle has no ack: mem_req drops, state=IDLE, enable_out=1, mem_fault=1, result_out=0, pc_out=faulting pc (all one cycle).
  - Ack and timeout in the same cycle: ack wins, no fault.
- Flush:
  - In IDLE: the incoming instruction is discarded; no output, no request.
  - In ACCESS: the request is not aborted; it is marked killed and still waits for ack/timeout.
  - Completion of a killed request produces enable_out=0 and mem_fault=0.
  - Flush has no effect on the cycle already presenting enable_out.
- enable ignored while stall_out=1; execute holds its inputs.
- Writeback never stalls; there is no output backpressure.
- mem_ack while in IDLE is ignored.

Test Plan:
- Reset release, then enable=1, pc_in=0x010, result_in=0x00ABCD, no mem op -> next cycle enable_out=1, pc_out=0x010, result_out=0x00ABCD; following cycle enable_out=0.
- Load pc=0x020, addr=0x155; mem_ack with mem_rdata=0x123456 on the 3rd ACCESS cycle -> mem_req high 3 cycles, mem_addr=0x155 stable, mem_we=0, stall_out high 3 cycles; then enable_out=1, result_out=0x123456, pc_out=0x020.
- Store addr=0x0FF, wdata=0x00BEEF; ack in the first ACCESS cycle -> mem_we=1, mem_wdata=0x00BEEF for 1 cycle; enable_out=1 the next cycle; next instruction accepted one cycle later.
- Load with no ack, TIMEOUT=16 -> mem_req high exactly 16 cycles; then enable_out=1, mem_fault=1, result_out=0; ack on cycle 16 instead -> no fault.
- Flush asserted in the 2nd ACCESS cycle of a load; ack on the 4th -> mem_req held 4 cycles, enable_out never asserted.
- rst=0 in the middle of ACCESS -> mem_req, stall_out and enable_out go 0 immediately without a clock edge; after release, state is IDLE.
